mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the single-port, 64 KiB synchronous memory between the 6502 core (port 0) and a DMA/loader requester (port 1). It accepts at most one access per clock and registers the winning address, write enable and write data onto the memory port. It then returns read data tagged to the originating port, aligned to the memory's one-cycle registered read. Port 0 has fixed priority, and a starvation counter guarantees port 1 forward progress.

## Interface
- STARVE_LIMIT, 4: consecutive port-0 grants allowed while port 1 waits; legal range 1..15.
- CLK  in  1  system clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- Req0 / Req1  in  1  access request; must be held with its qualifiers stable until granted.
- We0 / We1  in  1  1 = write, 0 = read.
- Addr0 / Addr1  in  16  byte address.
- WData0 / WData1  in  8  write data.
- Gnt0 / Gnt1  out  1  combinational accept; a transfer occurs on any rising edge where ReqN=1 and GntN=1.
- RValid0 / RValid1  out  1  RData holds the read result for that port this cycle.
- RData  out  8  read data; equals MemDataOut.
- MemWE  out  1  registered write enable to memory.
- MemAddr  out  16  registered memory address.
- MemDataIn  out  8  registered write data to memory.
- MemDataOut  in  8  registered read data from memory.

## Operation
- Grant logic, combinational, forced to 0 while RST_N=0:
  - starve = Req1 && (cnt == STARVE_LIMIT).
  - Gnt0 = Req0 && !starve.
  - Gnt1 = Req1 && !Gnt0.
  - At most one grant is high; an idle arbiter grants a lone requester in the same cycle.
- Starvation counter cnt, 4 bits, reset 0:
  - Gnt1 accept, or Req1=0: cnt <= 0.
  - Gnt0 accept while Req1=1: cnt <= cnt+1, saturating at STARVE_LIMIT.
  - Otherwise: hold.
- Issue stage, registered. On an accepted transfer, load MemAddr/MemWE/MemDataIn from the granted port. With no transfer, MemWE <= 0 and MemAddr/MemDataIn hold their previous values.
- Read tracking:
  - Stage 1: rd_v1 and rd_p1 capture (accepted && !We) and the granted port.
  - Stage 2: rd_v2 and rd_p2 follow stage 1 one cycle later.
  - RValid0 = rd_v2 && rd_p2==0; RValid1 = rd_v2 && rd_p2==1.
- Writes produce no RValid. Ordering is strictly in acceptance order. A read accepted the cycle after a write to the same address returns the new data.
- RData = MemDataOut, passed through without a register.

## Timing
- Accept edge E0 → Mem* valid after E0 → memory samples at E1 → RValid and RData valid for one cycle after E1. Read latency is 2 cycles from the accept edge.
- Throughput is one access per cycle across both ports. A lone requester holding Req gets back-to-back grants every cycle.
- Both ports requesting continuously give the pattern: STARVE_LIMIT port-0 grants, then 1 port-1 grant, repeating.
- Reset values: MemWE=0, MemAddr=0, MemDataIn=0, cnt=0, rd_v1=rd_v2=0, so RValid0=RValid1=0. Gnt0 and Gnt1 are 0 during reset.
- Reset asserted mid-operation: in-flight reads are discarded with no RValid, and MemWE drops immediately (asynchronously). After release, the first grant is possible in the first cycle with RST_N=1.
- Requester changing Addr/We/WData while Req=1 and Gnt=0: permitted, and the value present on the accept edge is used.
- Req dropped before being granted: no access is issued. cnt clears if Req1 drops.

## Test plan
- Preload 0x0037=0xDD; port 0 reads 0x0037 → Gnt0=1 same cycle; RValid0=1 and RData=0xDD exactly 2 cycles after accept; RValid1 stays 0.
- Port 1 writes 0x0108=0x5A, then reads 0x0108 on the next cycle → MemWE=1 for one cycle with MemAddr=0x0108; read returns 0x5A with RValid1 2 cycles after the read accept.
- Req0 and Req1 held high for 20 cycles, STARVE_LIMIT=4 → grant sequence 0,0,0,0,1 repeated 4 times; cnt never exceeds 4; RValid tags match issuing port in order.
- Req1 high while Req0 takes 3 grants, then Req1 drops for one cycle and reasserts → cnt clears; port 1 next granted after 4 further port-0 grants.
- Port 1 alone issues reads to 0x0300..0x0304 on consecutive cycles → 5 consecutive RValid1 cycles returning the preloaded bytes in address order.
- Assert RST_N=0 one cycle after a port-0 read accept → no RValid0 ever appears for it; all outputs 0 during reset; first post-reset read completes with normal 2-cycle latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Fixed-priority two-port arbiter in front of a single-port synchronous memory.
// Port 0 wins ties; a starvation counter forces a port-1 grant after STARVE_LIMIT port-0 wins.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        Req0,
    input  logic        Req1,
    input  logic        We0,
    input  logic        We1,
    input  logic [15:0] Addr0,
    input  logic [15:0] Addr1,
    input  logic [7:0]  WData0,
    input  logic [7:0]  WData1,
    output logic        Gnt0,
    output logic        Gnt1,
    output logic        RValid0,
    output logic        RValid1,
    output logic [7:0]  RData,
    output logic        MemWE,
    output logic [15:0] MemAddr,
    output logic [7:0]  MemDataIn,
    input  logic [7:0]  MemDataOut
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        starve;
    logic        gnt0;
    logic        gnt1;
    logic        accept;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [7:0]  sel_wdata;

    logic [3:0]  cnt_reg;
    logic [3:0]  cnt_next;
    logic        mem_we_reg;
    logic [15:0] mem_addr_reg;
    logic [7:0]  mem_wdata_reg;
    logic        rd_v1_reg;
    logic        rd_p1_reg;
    logic        rd_v2_reg;
    logic        rd_p2_reg;
    logic [1:0]  rvalid;

    // Grants are masked by reset so nothing is accepted while RST_N is low.
    always_comb begin
        starve    = Req1 && (cnt_reg == LIMIT);
        gnt0      = RST_N && Req0 && !starve;
        gnt1      = RST_N && Req1 && !gnt0;
        accept    = gnt0 || gnt1;
        sel_we    = gnt1 ? We1    : We0;
        sel_addr  = gnt1 ? Addr1  : Addr0;
        sel_wdata = gnt1 ? WData1 : WData0;
    end

    always_comb begin
        cnt_next = cnt_reg;
        if (!Req1 || gnt1) begin
            cnt_next = '0;
        end else if (gnt0 && (cnt_reg != LIMIT)) begin
            cnt_next = cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_reg       <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rd_v1_reg     <= 1'b0;
            rd_p1_reg     <= 1'b0;
            rd_v2_reg     <= 1'b0;
            rd_p2_reg     <= 1'b0;
        end else begin
            cnt_reg    <= cnt_next;
            mem_we_reg <= accept && sel_we;
            if (accept) begin
                mem_addr_reg  <= sel_addr;
                mem_wdata_reg <= sel_wdata;
            end
            // Two stages line up with the memory's registered read.
            rd_v1_reg <= accept && !sel_we;
            rd_p1_reg <= gnt1;
            rd_v2_reg <= rd_v1_reg;
            rd_p2_reg <= rd_p1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rvalid
            assign rvalid[gi] = rd_v2_reg && (rd_p2_reg == 1'(gi));
        end
    endgenerate

    assign Gnt0      = gnt0;
    assign Gnt1      = gnt1;
    assign RValid0   = rvalid[0];
    assign RValid1   = rvalid[1];
    assign RData     = MemDataOut;
    assign MemWE     = mem_we_reg;
    assign MemAddr   = mem_addr_reg;
    assign MemDataIn = mem_wdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 64 KiB registered-read memory.
// Inputs change 1 ns after the rising edge; outputs are sampled inside that window.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST_N;
    logic        Req0, Req1, We0, We1;
    logic [15:0] Addr0, Addr1;
    logic [7:0]  WData0, WData1;
    logic        Gnt0, Gnt1, RValid0, RValid1;
    logic [7:0]  RData;
    logic        MemWE;
    logic [15:0] MemAddr;
    logic [7:0]  MemDataIn;
    logic [7:0]  MemDataOut;

    logic        pl_we;
    logic [15:0] pl_addr;
    logic [7:0]  pl_data;
    logic [7:0]  mem [0:65535];

    int n_cmp;
    int n_bad;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Gnt0(Gnt0), .Gnt1(Gnt1), .RValid0(RValid0), .RValid1(RValid1),
        .RData(RData), .MemWE(MemWE), .MemAddr(MemAddr),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (MemWE) mem[MemAddr] <= MemDataIn;
        MemDataOut <= mem[MemAddr];
    end

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        cyc();
        pl_we = 1'b0;
    endtask

    task automatic test_reset;
        RST_N = 1'b0;
        Req0 = 1'b1; Req1 = 1'b1; We0 = 0; We1 = 0;
        Addr0 = 16'h0037; Addr1 = 16'h0108; WData0 = 8'h00; WData1 = 8'h00;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;
        cyc(); cyc();
        n_cmp++; if (Gnt0 !== 1'b0) begin n_bad++; $display("FAIL reset_gnt0: got %b want 0", Gnt0); end
        n_cmp++; if (Gnt1 !== 1'b0) begin n_bad++; $display("FAIL reset_gnt1: got %b want 0", Gnt1); end
        n_cmp++; if (MemWE !== 1'b0) begin n_bad++; $display("FAIL reset_memwe: got %b want 0", MemWE); end
        n_cmp++; if (MemAddr !== 16'h0000) begin n_bad++; $display("FAIL reset_memaddr: got %h want 0000", MemAddr); end
        n_cmp++; if (MemDataIn !== 8'h00) begin n_bad++; $display("FAIL reset_memdatain: got %h want 00", MemDataIn); end
        n_cmp++; if ({RValid0, RValid1} !== 2'b00) begin n_bad++; $display("FAIL reset_rvalid: got %b want 00", {RValid0, RValid1}); end
        Req0 = 1'b0; Req1 = 1'b0;
        preload(16'h0037, 8'hDD);
        for (int k = 0; k < 5; k++) preload(16'h0300 + 16'(k), 8'hC0 + 8'(k));
        RST_N = 1'b1;
        cyc(); cyc();
    endtask

    task automatic test_port0_read;
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0037;
        #1;
        n_cmp++; if ({Gnt0, Gnt1} !== 2'b10) begin n_bad++; $display("FAIL rd0_gnt: got %b want 10", {Gnt0, Gnt1}); end
        cyc();
        Req0 = 1'b0;
        n_cmp++; if (MemAddr !== 16'h0037) begin n_bad++; $display("FAIL rd0_memaddr: got %h want 0037", MemAddr); end
        n_cmp++; if (RValid0 !== 1'b0) begin n_bad++; $display("FAIL rd0_early: got %b want 0", RValid0); end
        cyc();
        n_cmp++; if (RValid0 !== 1'b1) begin n_bad++; $display("FAIL rd0_rvalid: got %b want 1", RValid0); end
        n_cmp++; if (RData !== 8'hDD) begin n_bad++; $display("FAIL rd0_rdata: got %h want dd", RData); end
        n_cmp++; if (RValid1 !== 1'b0) begin n_bad++; $display("FAIL rd0_rvalid1: got %b want 0", RValid1); end
        cyc();
        n_cmp++; if (RValid0 !== 1'b0) begin n_bad++; $display("FAIL rd0_oneshot: got %b want 0", RValid0); end
        cyc();
    endtask

    task automatic test_write_then_read;
        Req1 = 1'b1; We1 = 1'b1; Addr1 = 16'h0108; WData1 = 8'h5A;
        #1;
        n_cmp++; if ({Gnt0, Gnt1} !== 2'b01) begin n_bad++; $display("FAIL wr1_gnt: got %b want 01", {Gnt0, Gnt1}); end
        cyc();
        n_cmp++; if (MemWE !== 1'b1) begin n_bad++; $display("FAIL wr1_memwe: got %b want 1", MemWE); end
        n_cmp++; if (MemAddr !== 16'h0108) begin n_bad++; $display("FAIL wr1_memaddr: got %h want 0108", MemAddr); end
        n_cmp++; if (MemDataIn !== 8'h5A) begin n_bad++; $display("FAIL wr1_memdatain: got %h want 5a", MemDataIn); end
        We1 = 1'b0;
        #1;
        n_cmp++; if (Gnt1 !== 1'b1) begin n_bad++; $display("FAIL rd1_gnt: got %b want 1", Gnt1); end
        cyc();
        Req1 = 1'b0;
        n_cmp++; if (MemWE !== 1'b0) begin n_bad++; $display("FAIL wr1_oneshot: got %b want 0", MemWE); end
        n_cmp++; if (RValid1 !== 1'b0) begin n_bad++; $display("FAIL wr1_norvalid: got %b want 0", RValid1); end
        cyc();
        n_cmp++; if (RValid1 !== 1'b1) begin n_bad++; $display("FAIL rd1_rvalid: got %b want 1", RValid1); end
        n_cmp++; if (RData !== 8'h5A) begin n_bad++; $display("FAIL rd1_rdata: got %h want 5a", RData); end
        n_cmp++; if (RValid0 !== 1'b0) begin n_bad++; $display("FAIL rd1_rvalid0: got %b want 0", RValid0); end
        cyc(); cyc();
    endtask

    task automatic test_starvation;
        int gq[$];
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0037;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 16'h0108;
        for (int i = 0; i < 22; i++) begin
            int p;
            if (i == 20) begin Req0 = 1'b0; Req1 = 1'b0; end
            #1;
            if (i < 20) begin
                p = (i % 5 == 4) ? 1 : 0;
                gq.push_back(p);
                n_cmp++;
                if ({Gnt0, Gnt1} !== {p == 0, p == 1}) begin
                    n_bad++; $display("FAIL starve_gnt[%0d]: got %b want %b", i, {Gnt0, Gnt1}, {p == 0, p == 1});
                end
            end
            if (i >= 2) begin
                p = gq[i-2];
                n_cmp++;
                if ({RValid0, RValid1} !== {p == 0, p == 1}) begin
                    n_bad++; $display("FAIL starve_tag[%0d]: got %b want %b", i, {RValid0, RValid1}, {p == 0, p == 1});
                end
                n_cmp++;
                if (RData !== ((p == 1) ? 8'h5A : 8'hDD)) begin
                    n_bad++; $display("FAIL starve_rdata[%0d]: got %h want %h", i, RData, (p == 1) ? 8'h5A : 8'hDD);
                end
            end
            cyc();
        end
        cyc();
    endtask

    task automatic test_req1_drop;
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0037;
        We1 = 1'b0; Addr1 = 16'h0108;
        for (int i = 0; i < 9; i++) begin
            logic exp1;
            Req1 = (i != 3);
            exp1 = (i == 8);
            #1;
            n_cmp++;
            if ({Gnt0, Gnt1} !== {!exp1, exp1}) begin
                n_bad++; $display("FAIL drop_gnt[%0d]: got %b want %b", i, {Gnt0, Gnt1}, {!exp1, exp1});
            end
            cyc();
        end
        Req0 = 1'b0; Req1 = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    task automatic test_back_to_back;
        We1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            Req1 = (i < 5);
            Addr1 = 16'h0300 + 16'(i);
            #1;
            if (i < 5) begin
                n_cmp++; if (Gnt1 !== 1'b1) begin n_bad++; $display("FAIL b2b_gnt[%0d]: got %b want 1", i, Gnt1); end
            end
            if (i >= 2 && i < 7) begin
                n_cmp++; if (RValid1 !== 1'b1) begin n_bad++; $display("FAIL b2b_rvalid[%0d]: got %b want 1", i, RValid1); end
                n_cmp++; if (RData !== 8'hC0 + 8'(i - 2)) begin n_bad++; $display("FAIL b2b_rdata[%0d]: got %h want %h", i, RData, 8'hC0 + 8'(i - 2)); end
            end else begin
                n_cmp++; if (RValid1 !== 1'b0) begin n_bad++; $display("FAIL b2b_idle[%0d]: got %b want 0", i, RValid1); end
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid;
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 16'h0037; WData0 = 8'h33;
        #1;
        n_cmp++; if (Gnt0 !== 1'b1) begin n_bad++; $display("FAIL rst_pre_gnt: got %b want 1", Gnt0); end
        cyc();
        n_cmp++; if (MemDataIn !== 8'h33) begin n_bad++; $display("FAIL rst_pre_datain: got %h want 33", MemDataIn); end
        RST_N = 1'b0;
        #1;
        n_cmp++; if ({Gnt0, Gnt1} !== 2'b00) begin n_bad++; $display("FAIL rst_gnt: got %b want 00", {Gnt0, Gnt1}); end
        n_cmp++; if (MemAddr !== 16'h0000) begin n_bad++; $display("FAIL rst_memaddr: got %h want 0000", MemAddr); end
        n_cmp++; if (MemDataIn !== 8'h00) begin n_bad++; $display("FAIL rst_memdatain: got %h want 00", MemDataIn); end
        n_cmp++; if (MemWE !== 1'b0) begin n_bad++; $display("FAIL rst_memwe: got %b want 0", MemWE); end
        for (int i = 0; i < 2; i++) begin
            cyc();
            n_cmp++; if ({RValid0, RValid1} !== 2'b00) begin n_bad++; $display("FAIL rst_discard[%0d]: got %b want 00", i, {RValid0, RValid1}); end
        end
        RST_N = 1'b1;
        #1;
        n_cmp++; if (Gnt0 !== 1'b1) begin n_bad++; $display("FAIL rst_first_gnt: got %b want 1", Gnt0); end
        cyc();
        Req0 = 1'b0;
        n_cmp++; if (RValid0 !== 1'b0) begin n_bad++; $display("FAIL rst_post_early: got %b want 0", RValid0); end
        cyc();
        n_cmp++; if (RValid0 !== 1'b1) begin n_bad++; $display("FAIL rst_post_rvalid: got %b want 1", RValid0); end
        n_cmp++; if (RData !== 8'hDD) begin n_bad++; $display("FAIL rst_post_rdata: got %h want dd", RData); end
        cyc();
        n_cmp++; if (RValid0 !== 1'b0) begin n_bad++; $display("FAIL rst_post_oneshot: got %b want 0", RValid0); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_port0_read();
        test_write_then_read();
        test_starvation();
        test_req1_drop();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
